// File: rtl/gs_pkg.sv
// Shared definitions for the NGS-side GS mailbox ports: port map, cycle FSM states, status fill.
// Imported by the cycle tracker, the port block and the interface.
package gs_pkg;

  localparam int ADDR_BITS = 4;

  typedef logic [ADDR_BITS-1:0] gs_addr_t;

  localparam gs_addr_t PORT_CMD     = 4'h1;
  localparam gs_addr_t PORT_DATRD   = 4'h2;
  localparam gs_addr_t PORT_DATWR   = 4'h3;
  localparam gs_addr_t PORT_STAT    = 4'h4;
  localparam gs_addr_t PORT_CLRCBIT = 4'h5;

  localparam logic [5:0] STAT_FILL = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACT  = 2'd1,
    HOLD = 2'd2
  } gs_state_e;

  function automatic logic port_hit(input gs_addr_t addr);
    return (addr == PORT_CMD) || (addr == PORT_DATRD) || (addr == PORT_DATWR) ||
           (addr == PORT_STAT) || (addr == PORT_CLRCBIT);
  endfunction

  // The write-data port has nothing to return, so reads of it leave the bus undriven.
  function automatic logic port_readable(input gs_addr_t addr);
    return port_hit(addr) && (addr != PORT_DATWR);
  endfunction

endpackage

// File: rtl/gs_ports_if.sv
// Bundle of NGS Z80 bus signals and ZX-side mailbox register/flag signals seen by gs_ports.
// slave is the port block's view; master is the view of whatever drives the Z80 bus and ZX side.
interface gs_ports_if;
  import gs_pkg::*;

  gs_addr_t     a;
  logic [7:0]   din;
  logic [7:0]   dout;
  logic         dout_ena;
  logic         iorq_n;
  logic         rd_n;
  logic         wr_n;
  logic         m1_n;

  logic [7:0]   command_reg_in;
  logic [7:0]   data_reg_in;
  logic [7:0]   data_reg_out;
  logic         data_bit;
  logic         command_bit;
  logic         data_bit_in;
  logic         command_bit_in;
  logic         data_bit_wr;
  logic         command_bit_wr;

  modport slave (
    input  a, din, iorq_n, rd_n, wr_n, m1_n,
    input  command_reg_in, data_reg_in, data_bit, command_bit,
    output dout, dout_ena, data_reg_out,
    output data_bit_in, command_bit_in, data_bit_wr, command_bit_wr
  );

  modport master (
    output a, din, iorq_n, rd_n, wr_n, m1_n,
    output command_reg_in, data_reg_in, data_bit, command_bit,
    input  dout, dout_ena, data_reg_out,
    input  data_bit_in, command_bit_in, data_bit_wr, command_bit_wr
  );

endinterface

// File: rtl/gs_iocycle.sv
// Samples Z80 I/O strobes/address/data and tracks one I/O cycle as IDLE -> ACT -> HOLD.
// start fires once per decoded cycle (the IDLE->ACT edge); cycle_end marks HOLD->IDLE.
module gs_iocycle
  import gs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  gs_addr_t   a,
  input  logic [7:0] din,
  output gs_addr_t   a_q,
  output logic [7:0] din_q,
  output logic       iord_q,
  output logic       iowr_q,
  output gs_state_e  state_q,
  output logic       start,
  output logic       cycle_end
);

  logic       iord_d;
  logic       iowr_d;
  gs_addr_t   a_d;
  logic [7:0] din_d;
  gs_state_e  state_d;

  // m1_n low means interrupt acknowledge, which must never look like a port access.
  always_comb begin
    iord_d = !iorq_n && !rd_n && m1_n;
    iowr_d = !iorq_n && !wr_n && m1_n;
    a_d    = a;
    din_d  = din;
  end

  assign start     = (state_q == IDLE) && (iord_q || iowr_q) && port_hit(a_q);
  assign cycle_end = (state_q == HOLD) && !iord_q && !iowr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACT;
      ACT:     state_d = HOLD;
      HOLD:    if (cycle_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iord_q  <= 1'b0;
      iowr_q  <= 1'b0;
      a_q     <= '0;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      iord_q  <= iord_d;
      iowr_q  <= iowr_d;
      a_q     <= a_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: rtl/gs_ports.sv
// NGS-side end of the ZX<->GS mailbox: decodes Z80 I/O to five GS ports, returns read data,
// latches the outgoing data register and issues one flag-load strobe per qualifying cycle.
module gs_ports
  import gs_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       rst_n,
  gs_ports_if.slave  bus
);

  gs_addr_t   a_q;
  logic [7:0] din_q;
  logic       iord_q;
  logic       iowr_q;
  gs_state_e  state_q;
  logic       start;
  logic       cycle_end;

  gs_iocycle u_io (
    .clk       (cpu_clock),
    .rst_n     (rst_n),
    .iorq_n    (bus.iorq_n),
    .rd_n      (bus.rd_n),
    .wr_n      (bus.wr_n),
    .m1_n      (bus.m1_n),
    .a         (bus.a),
    .din       (bus.din),
    .a_q       (a_q),
    .din_q     (din_q),
    .iord_q    (iord_q),
    .iowr_q    (iowr_q),
    .state_q   (state_q),
    .start     (start),
    .cycle_end (cycle_end)
  );

  logic [7:0] dout_q, dout_d;
  logic       dout_ena_q, dout_ena_d;
  logic [7:0] data_reg_out_q, data_reg_out_d;
  logic       data_bit_in_q, data_bit_in_d;
  logic       data_bit_wr_q, data_bit_wr_d;
  logic       command_bit_in_q, command_bit_in_d;
  logic       command_bit_wr_q, command_bit_wr_d;

  logic rd_start;
  logic wr_start;

  assign rd_start = start && iord_q;
  assign wr_start = start && iowr_q && !iord_q;

  // All side effects are launched on the IDLE->ACT edge, so they appear while ACT is held
  // and a wait-stated cycle can never repeat them.
  always_comb begin
    dout_d           = dout_q;
    dout_ena_d       = dout_ena_q;
    data_reg_out_d   = data_reg_out_q;
    data_bit_in_d    = data_bit_in_q;
    data_bit_wr_d    = 1'b0;
    command_bit_in_d = command_bit_in_q;
    command_bit_wr_d = 1'b0;

    if (rd_start) begin
      dout_ena_d = port_readable(a_q);
      case (a_q)
        PORT_CMD:     dout_d = bus.command_reg_in;
        PORT_DATRD:   dout_d = bus.data_reg_in;
        PORT_STAT:    dout_d = {bus.data_bit, STAT_FILL, bus.command_bit};
        PORT_CLRCBIT: dout_d = 8'hFF;
        default:      dout_d = dout_q;
      endcase
      if (a_q == PORT_DATRD) begin
        data_bit_in_d = 1'b0;
        data_bit_wr_d = 1'b1;
      end
    end else if (cycle_end || (state_q == IDLE)) begin
      dout_ena_d = 1'b0;
    end

    if (wr_start && (a_q == PORT_DATWR)) begin
      data_reg_out_d = din_q;
      data_bit_in_d  = 1'b1;
      data_bit_wr_d  = 1'b1;
    end

    if (start && (a_q == PORT_CLRCBIT)) begin
      command_bit_in_d = 1'b0;
      command_bit_wr_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      dout_q           <= 8'hFF;
      dout_ena_q       <= 1'b0;
      data_reg_out_q   <= 8'h00;
      data_bit_in_q    <= 1'b0;
      data_bit_wr_q    <= 1'b0;
      command_bit_in_q <= 1'b0;
      command_bit_wr_q <= 1'b0;
    end else begin
      dout_q           <= dout_d;
      dout_ena_q       <= dout_ena_d;
      data_reg_out_q   <= data_reg_out_d;
      data_bit_in_q    <= data_bit_in_d;
      data_bit_wr_q    <= data_bit_wr_d;
      command_bit_in_q <= command_bit_in_d;
      command_bit_wr_q <= command_bit_wr_d;
    end
  end

  assign bus.dout           = dout_q;
  assign bus.dout_ena       = dout_ena_q;
  assign bus.data_reg_out   = data_reg_out_q;
  assign bus.data_bit_in    = data_bit_in_q;
  assign bus.data_bit_wr    = data_bit_wr_q;
  assign bus.command_bit_in = command_bit_in_q;
  assign bus.command_bit_wr = command_bit_wr_q;

endmodule
